// File: rtl/sort_pkg.sv
// Shared types and constants for the sorting-stack frame sequencer.
// Holds the FSM state enum, the default geometry and the counter-width helper.
package sort_pkg;

    localparam int unsigned SortWidth = 16;
    localparam int unsigned SortDepth = 8;

    typedef enum logic [1:0] {
        StFlush,
        StLoad,
        StDrain,
        StSkip
    } sort_state_e;

    // Width needed to hold a count from 0 up to and including depth.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sort_frame_ctrl_if.sv
// Valid/ready sample stream with end-of-frame marker.
// The master drives valid/data/last; the slave drives ready.
interface sort_frame_ctrl_if #(
    parameter int unsigned WIDTH = sort_pkg::SortWidth
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;
    logic             last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/sort_frame_fsm.sv
// Frame sequencing FSM: state, frame count, pop index and truncation flag.
// SORT_FRAME_MEDIAN_EN adds the mid_pop decode used by the median latch.
module sort_frame_fsm
    import sort_pkg::*;
#(
    parameter int unsigned  DEPTH = SortDepth,
    localparam int unsigned CntW  = cnt_width(DEPTH)
) (
    input  logic        clk,
    input  logic        hard_reset_n,
    input  logic        in_valid,
    input  logic        in_last,
    input  logic        out_ready,
    output sort_state_e state,
    output logic        in_ready,
    output logic        out_valid,
    output logic        out_last,
    output logic        stk_is_input,
    output logic        frame_trunc
`ifdef SORT_FRAME_MEDIAN_EN
   ,output logic        mid_pop
`endif
);

    localparam logic [CntW-1:0] One       = CntW'(1);
    localparam logic [CntW-1:0] CntMax    = CntW'(DEPTH);
    localparam logic [CntW-1:0] FlushLast = CntW'(DEPTH - 1);

    sort_state_e     state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [CntW-1:0] pidx_q, pidx_d;
    logic            trunc_q, trunc_d;
    logic            frame_trunc_q, frame_trunc_d;

    logic            in_hs;
    logic            out_hs;
    logic [CntW-1:0] cnt_inc;

    assign in_hs   = in_valid & in_ready;
    assign out_hs  = out_valid & out_ready;
    assign cnt_inc = cnt_q + One;

    always_ff @(posedge clk or negedge hard_reset_n) begin
        if (!hard_reset_n) begin
            state_q       <= StFlush;
            cnt_q         <= '0;
            pidx_q        <= '0;
            trunc_q       <= 1'b0;
            frame_trunc_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pidx_q        <= pidx_d;
            trunc_q       <= trunc_d;
            frame_trunc_q <= frame_trunc_d;
        end
    end

    // pidx doubles as the pop counter while flushing stale stack contents.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pidx_d        = pidx_q;
        trunc_d       = trunc_q;
        frame_trunc_d = 1'b0;
        unique case (state_q)
            StFlush: begin
                if (pidx_q == FlushLast) begin
                    state_d = StLoad;
                    pidx_d  = '0;
                    cnt_d   = '0;
                end else begin
                    pidx_d = pidx_q + One;
                end
            end
            StLoad: begin
                if (in_hs) begin
                    cnt_d = cnt_inc;
                    if (in_last) begin
                        state_d = StDrain;
                    end else if (cnt_inc == CntMax) begin
                        state_d       = StDrain;
                        trunc_d       = 1'b1;
                        frame_trunc_d = 1'b1;
                    end
                end
            end
            StDrain: begin
                if (out_hs) begin
                    if (out_last) begin
                        cnt_d   = '0;
                        pidx_d  = '0;
                        state_d = trunc_q ? StSkip : StLoad;
                    end else begin
                        pidx_d = pidx_q + One;
                    end
                end
            end
            StSkip: begin
                if (in_hs && in_last) begin
                    trunc_d = 1'b0;
                    state_d = StLoad;
                end
            end
            default: state_d = StFlush;
        endcase
    end

    always_comb begin
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        out_last     = 1'b0;
        stk_is_input = 1'b0;
        unique case (state_q)
            StLoad: begin
                in_ready     = 1'b1;
                stk_is_input = 1'b1;
            end
            StDrain: begin
                out_valid = 1'b1;
                out_last  = (pidx_q == (cnt_q - One));
            end
            StSkip:  in_ready = 1'b1;
            default: ;
        endcase
    end

    assign state       = state_q;
    assign frame_trunc = frame_trunc_q;

`ifdef SORT_FRAME_MEDIAN_EN
    // Lower median: index cnt/2 counted from the largest value.
    assign mid_pop = out_hs && (pidx_q == (cnt_q >> 1));
`endif

endmodule

// File: rtl/sort_frame_ctrl.sv
// Frame sequencer in front of the systolic sorting stack: push a frame, pop it descending.
// Define SORT_FRAME_MEDIAN_EN to add the median/median_stb outputs.
module sort_frame_ctrl
    import sort_pkg::*;
#(
    parameter int unsigned WIDTH = SortWidth,
    parameter int unsigned DEPTH = SortDepth
) (
    input  logic              clk,
    input  logic              hard_reset_n,
    sort_frame_ctrl_if.slave  in_bus,
    sort_frame_ctrl_if.master out_bus,
    output logic              stk_hold,
    output logic              stk_is_input,
    output logic [WIDTH-1:0]  stk_data_in,
    input  logic [WIDTH-1:0]  stk_data_out,
    output logic              frame_trunc
`ifdef SORT_FRAME_MEDIAN_EN
   ,output logic [WIDTH-1:0]  median,
    output logic              median_stb
`endif
);

    sort_state_e state;
    logic        in_ready;
    logic        out_valid;
    logic        out_last;
`ifdef SORT_FRAME_MEDIAN_EN
    logic        mid_pop;
`endif

    sort_frame_fsm #(
        .DEPTH (DEPTH)
    ) u_fsm (
        .clk          (clk),
        .hard_reset_n (hard_reset_n),
        .in_valid     (in_bus.valid),
        .in_last      (in_bus.last),
        .out_ready    (out_bus.ready),
        .state        (state),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_last     (out_last),
        .stk_is_input (stk_is_input),
        .frame_trunc  (frame_trunc)
`ifdef SORT_FRAME_MEDIAN_EN
       ,.mid_pop      (mid_pop)
`endif
    );

    assign in_bus.ready  = in_ready;
    assign out_bus.valid = out_valid;
    assign out_bus.last  = out_last;
    assign out_bus.data  = stk_data_out;
    assign stk_data_in   = in_bus.data;

    // Flush pops every cycle; skipped beats must never reach the stack.
    always_comb begin
        stk_hold = 1'b1;
        unique case (state)
            StFlush: stk_hold = 1'b0;
            StLoad:  stk_hold = ~(in_bus.valid & in_ready);
            StDrain: stk_hold = ~out_bus.ready;
            default: stk_hold = 1'b1;
        endcase
    end

`ifdef SORT_FRAME_MEDIAN_EN
    logic [WIDTH-1:0] median_q;
    logic             median_stb_q;

    always_ff @(posedge clk or negedge hard_reset_n) begin
        if (!hard_reset_n) begin
            median_q     <= '0;
            median_stb_q <= 1'b0;
        end else begin
            median_stb_q <= mid_pop;
            if (mid_pop) begin
                median_q <= stk_data_out;
            end
        end
    end

    assign median     = median_q;
    assign median_stb = median_stb_q;
`endif

endmodule

// File: tb/tb_sort_frame_ctrl.sv
// Directed bench for sort_frame_ctrl with a behavioural sorting-stack model.
// Median checks are active when SORT_FRAME_MEDIAN_EN is defined.
module tb_sort_frame_ctrl;
    import sort_pkg::*;

    localparam int unsigned W = 16;
    localparam int unsigned D = 8;

    logic clk = 1'b0;
    logic hard_reset_n = 1'b0;
    always #5 clk = ~clk;

    sort_frame_ctrl_if #(.WIDTH(W)) in_bus ();
    sort_frame_ctrl_if #(.WIDTH(W)) out_bus ();

    logic         stk_hold;
    logic         stk_is_input;
    logic [W-1:0] stk_data_in;
    logic [W-1:0] stk_data_out;
    logic         frame_trunc;
`ifdef SORT_FRAME_MEDIAN_EN
    logic [W-1:0] median;
    logic         median_stb;
`endif

    sort_frame_ctrl #(
        .WIDTH (W),
        .DEPTH (D)
    ) dut (
        .clk          (clk),
        .hard_reset_n (hard_reset_n),
        .in_bus       (in_bus),
        .out_bus      (out_bus),
        .stk_hold     (stk_hold),
        .stk_is_input (stk_is_input),
        .stk_data_in  (stk_data_in),
        .stk_data_out (stk_data_out),
        .frame_trunc  (frame_trunc)
`ifdef SORT_FRAME_MEDIAN_EN
       ,.median       (median),
        .median_stb   (median_stb)
`endif
    );

    // Stack model: kept sorted descending, head is the maximum, zeros fill from the tail.
    typedef logic [W-1:0] stk_t [D];
    stk_t stk = '{16'hAAAA, 16'hAAA9, 16'hAAA8, 16'hAAA7,
                  16'hAAA6, 16'hAAA5, 16'hAAA4, 16'hAAA3};

    function automatic stk_t stk_push(input stk_t a, input logic [W-1:0] v);
        stk_t r;
        bit   placed;
        r      = a;
        placed = 1'b0;
        for (int i = 0; i < D; i++) begin
            if (!placed && v > a[i]) begin
                r[i]   = v;
                placed = 1'b1;
            end else if (placed) begin
                r[i] = a[(i > 0) ? i - 1 : 0];
            end
        end
        return r;
    endfunction

    function automatic stk_t stk_pop(input stk_t a);
        stk_t r;
        for (int i = 0; i < D - 1; i++) r[i] = a[i + 1];
        r[D-1] = '0;
        return r;
    endfunction

    assign stk_data_out = stk[0];

    always @(posedge clk) begin
        if (!stk_hold) stk <= stk_is_input ? stk_push(stk, stk_data_in) : stk_pop(stk);
    end

    int n_run  = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int trunc_n   = 0;
    int trunc_cyc = -1;
    int stb_n     = 0;
    initial forever begin
        @(negedge clk);
        #1;
        if (frame_trunc) begin
            trunc_n++;
            trunc_cyc = cyc;
        end
`ifdef SORT_FRAME_MEDIAN_EN
        if (median_stb) stb_n++;
`endif
    end

    int tx_q[$];
    int rx_q[$];
    int hs_cyc[16];
    logic hold_hs[16];
    int first_valid_cyc;
    logic [3:0] stall_pat = 4'b1001;

    task automatic send_frame(input int n_tx, input int last_at);
        for (int i = 0; i < n_tx; i++) begin
            int waited;
            waited = 0;
            @(negedge clk);
            in_bus.valid = 1'b1;
            in_bus.data  = W'(tx_q[i]);
            in_bus.last  = (i == last_at);
            #1;
            while (!in_bus.ready && waited < 100) begin
                @(negedge clk);
                #1;
                waited++;
            end
            check_eq("in_accept", 32'(in_bus.ready), 1);
            hs_cyc[i]  = cyc;
            hold_hs[i] = stk_hold;
        end
        @(negedge clk);
        in_bus.valid = 1'b0;
        in_bus.last  = 1'b0;
    endtask

    task automatic recv_frame(input int n_rx, input bit stall);
        int           got;
        int           k;
        bit           stalled;
        logic [W-1:0] held;
        got             = 0;
        k               = 0;
        stalled         = 1'b0;
        held            = '0;
        first_valid_cyc = -1;
        while (got < n_rx && k < 200) begin
            @(negedge clk);
            out_bus.ready = stall ? stall_pat[k % 4] : 1'b1;
            #1;
            if (out_bus.valid) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (stalled) check_eq("stall_data", 32'(out_bus.data), 32'(held));
                check_eq("in_ready_drain", 32'(in_bus.ready), 0);
                if (out_bus.ready) begin
                    check_eq("out_data", 32'(out_bus.data), rx_q[got]);
                    check_eq("out_last", 32'(out_bus.last), 32'(got == n_rx - 1));
                    check_eq("hold_pop", 32'(stk_hold), 0);
                    got++;
                    stalled = 1'b0;
                end else begin
                    check_eq("hold_stall", 32'(stk_hold), 1);
                    held    = out_bus.data;
                    stalled = 1'b1;
                end
            end
            k++;
        end
        check_eq("rx_count", got, n_rx);
        @(negedge clk);
        out_bus.ready = 1'b1;
    endtask

    task automatic run_frame(input int n_tx, input int last_at, input int n_rx, input bit stall);
        fork
            send_frame(n_tx, last_at);
            recv_frame(n_rx, stall);
        join
        repeat (2) @(negedge clk);
        #2;
    endtask

    task automatic wait_flush();
        int n;
        bit bad;
        n   = 0;
        bad = 1'b0;
        #1;
        while (!in_bus.ready && n < 40) begin
            if (stk_hold || stk_is_input || out_bus.valid) bad = 1'b1;
            n++;
            @(negedge clk);
            #1;
        end
        check_eq("flush_cycles", n, D);
        check_eq("flush_pop_only", 32'(bad), 0);
        check_eq("load_in_ready", 32'(in_bus.ready), 1);
        check_eq("load_out_valid", 32'(out_bus.valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        in_bus.valid  = 1'b0;
        in_bus.data   = '0;
        in_bus.last   = 1'b0;
        out_bus.ready = 1'b1;
        hard_reset_n  = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_in_ready", 32'(in_bus.ready), 0);
        check_eq("rst_out_valid", 32'(out_bus.valid), 0);
        check_eq("rst_stk_hold", 32'(stk_hold), 0);
        check_eq("rst_stk_is_input", 32'(stk_is_input), 0);
        check_eq("rst_frame_trunc", 32'(frame_trunc), 0);
`ifdef SORT_FRAME_MEDIAN_EN
        check_eq("rst_median", 32'(median), 0);
        check_eq("rst_median_stb", 32'(median_stb), 0);
`endif
        @(negedge clk);
        hard_reset_n = 1'b1;
        wait_flush();

        // Basic frame
        tx_q = '{5, 1, 9, 3, 7};
        rx_q = '{9, 7, 5, 3, 1};
        run_frame(5, 4, 5, 1'b0);
        check_eq("first_valid_latency", first_valid_cyc, hs_cyc[4] + 1);
`ifdef SORT_FRAME_MEDIAN_EN
        check_eq("median_f1", 32'(median), 5);
        check_eq("median_stb_f1", stb_n, 1);
`endif

        // Same frame under backpressure
        run_frame(5, 4, 5, 1'b1);
`ifdef SORT_FRAME_MEDIAN_EN
        check_eq("median_stb_f2", stb_n, 2);
`endif

        // Ten beats: cut at DEPTH, beats 9 and 10 skipped
        tx_q = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
        rx_q = '{8, 7, 6, 5, 4, 3, 2, 1};
        run_frame(10, 9, 8, 1'b0);
        check_eq("trunc_pulses", trunc_n, 1);
        check_eq("trunc_timing", trunc_cyc, hs_cyc[7] + 1);
        check_eq("push_beat8", 32'(hold_hs[7]), 0);
        check_eq("skip_beat9", 32'(hold_hs[8]), 1);
        check_eq("skip_beat10", 32'(hold_hs[9]), 1);
`ifdef SORT_FRAME_MEDIAN_EN
        check_eq("median_trunc", 32'(median), 4);
`endif

        tx_q = '{4, 4};
        rx_q = '{4, 4};
        run_frame(2, 1, 2, 1'b0);
        check_eq("after_skip_push", 32'(hold_hs[0]), 0);
        check_eq("trunc_pulses_f4", trunc_n, 1);

        // Last on the DEPTH-th beat is a normal end of frame
        tx_q = '{3, 8, 1, 6, 2, 7, 4, 5};
        rx_q = '{8, 7, 6, 5, 4, 3, 2, 1};
        run_frame(8, 7, 8, 1'b0);
        check_eq("full_no_trunc", trunc_n, 1);

        // Single beat at full scale; must load directly (no SKIP)
        tx_q = '{65535};
        rx_q = '{65535};
        run_frame(1, 0, 1, 1'b0);
        check_eq("full_then_load", 32'(hold_hs[0]), 0);
`ifdef SORT_FRAME_MEDIAN_EN
        check_eq("median_single", 32'(median), 65535);
`endif

        // Reset in the middle of a frame
        tx_q = '{5, 1, 9};
        send_frame(3, -1);
        @(negedge clk);
        hard_reset_n = 1'b0;
        #1;
        check_eq("midrst_in_ready", 32'(in_bus.ready), 0);
        check_eq("midrst_out_valid", 32'(out_bus.valid), 0);
`ifdef SORT_FRAME_MEDIAN_EN
        check_eq("midrst_median", 32'(median), 0);
`endif
        @(negedge clk);
        hard_reset_n = 1'b1;
        wait_flush();
        tx_q = '{2, 6};
        rx_q = '{6, 2};
        run_frame(2, 1, 2, 1'b0);
`ifdef SORT_FRAME_MEDIAN_EN
        check_eq("median_after_rst", 32'(median), 2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/sort_frame_ctrl.md
# sort_frame_ctrl

Frame sequencer sitting directly upstream of the systolic sorting stack. Accepts a stream of unsigned samples as frames, pushes each frame into the stack, then pops it back out in descending order on a backpressured output stream. Optionally latches the frame median for the filter path. Also flushes stale stack contents after reset, since the stack cells have no reset.

## Interface
- WIDTH, 16, sample width in bits; must match the stack's HBIT+1
- DEPTH, 8, maximum frame length; must not exceed the stack capacity (2 values per cell)
- CLK  in  1  single clock, rising edge
- HARD_RESET_N  in  1  reset, asynchronous, active-low
- IN_VALID  in  1  input sample valid
- IN_READY  out  1  input sample accepted when IN_VALID & IN_READY
- IN_DATA  in  WIDTH  input sample, unsigned
- IN_LAST  in  1  marks the last sample of a frame
- STK_HOLD  out  1  stack clock-enable, active-high hold
- STK_IS_INPUT  out  1  1 = push, 0 = pop
- STK_DATA_IN  out  WIDTH  value pushed into the stack
- STK_DATA_OUT  in  WIDTH  stack head; the current maximum while popping
- OUT_VALID  out  1  sorted sample valid
- OUT_READY  in  1  downstream accepts
- OUT_DATA  out  WIDTH  sorted sample, largest first
- OUT_LAST  out  1  marks the last sorted sample of a frame
- FRAME_TRUNC  out  1  one-cycle pulse when a frame is cut at DEPTH

## Operation
- Stack contract:
  - Each cycle with STK_HOLD=0 and STK_IS_INPUT=1 pushes STK_DATA_IN.
  - With STK_IS_INPUT=0, STK_DATA_OUT shows the current maximum combinationally. A cycle with STK_HOLD=0 pops that value, and zero fills in from the tail.
- FSM states: FLUSH, LOAD, DRAIN, SKIP.
- Frame counter `cnt` has width $clog2(DEPTH+1).
- Pop index `pidx` has the same width.
- FLUSH (entered on reset):
  - STK_IS_INPUT=0, STK_HOLD=0, IN_READY=0, OUT_VALID=0.
  - Pops DEPTH cycles and discards the data, leaving the stack all zeros.
  - Then goes to LOAD with cnt=0.
- LOAD:
  - IN_READY=1, STK_IS_INPUT=1, STK_DATA_IN=IN_DATA, STK_HOLD=~(IN_VALID & IN_READY).
  - On each handshake, cnt increments.
  - A handshake with IN_LAST goes to DRAIN.
  - A handshake that makes cnt==DEPTH without IN_LAST goes to DRAIN, sets the truncation flag, and pulses FRAME_TRUNC.
- DRAIN:
  - STK_IS_INPUT=0, OUT_VALID=1, OUT_DATA=STK_DATA_OUT, STK_HOLD=~OUT_READY.
  - OUT_LAST=(pidx==cnt-1).
  - On each handshake, pidx increments.
  - A handshake with OUT_LAST clears cnt and pidx. If the truncation flag is set, go to SKIP; otherwise go to LOAD.
- SKIP:
  - IN_READY=1, STK_HOLD=1; beats are discarded.
  - A handshake with IN_LAST clears the truncation flag and goes to LOAD.
- Stack zeros sink below every pushed value, because the comparison is unsigned. Popping exactly cnt values therefore returns only frame data and leaves the stack all zeros.
- Frame length 1 is legal: DRAIN emits one beat with OUT_LAST=1.

## Timing
- Reset values: state=FLUSH, cnt=0, pidx=0, truncation flag=0, FRAME_TRUNC=0. This gives IN_READY=0, OUT_VALID=0, STK_HOLD=0, STK_IS_INPUT=0.
- Reset asserted mid-frame: the partial frame is lost and the FSM restarts in FLUSH. The stack is not trusted; FLUSH clears it.
- Push throughput is 1 sample/cycle; pop throughput is 1 sample/cycle.
- First OUT_VALID is the cycle after the last input handshake. OUT_DATA has zero latency from the stack head.
- OUT_VALID stays high under backpressure. OUT_DATA and OUT_LAST stay stable while OUT_READY=0, because the stack is held.
- IN_READY is 0 throughout DRAIN. The input and output phases never overlap.
- FRAME_TRUNC is high for exactly the cycle after the truncating handshake.
- IN_LAST on the DEPTH-th beat is a normal end of frame: no truncation, no SKIP.

## Configuration
- Macro: SORT_FRAME_MEDIAN_EN.
- Defined:
  - Adds output MEDIAN (WIDTH, reset 0) and MEDIAN_STB (1, reset 0).
  - At the DRAIN handshake with pidx==cnt/2 (integer division; lower median for even cnt), MEDIAN<=OUT_DATA.
  - MEDIAN_STB pulses for the following cycle. MEDIAN holds its value until the next frame.
- Undefined: the MEDIAN and MEDIAN_STB ports and their logic are absent.

## Structure
- Shared package sort_pkg holds:
  - the state enum (FLUSH/LOAD/DRAIN/SKIP)
  - the default WIDTH=16 and DEPTH=8 constants
  - a counter-width function.
- One sub-module, sort_frame_fsm: state register, cnt, pidx and the truncation flag.
- The datapath muxing stays in the top level.

## Test plan
- Reset, then idle → 8 cycles with STK_HOLD=0 and STK_IS_INPUT=0, then IN_READY=1 and OUT_VALID=0.
- Frame 5,1,9,3,7 with IN_LAST on 7 → OUT_DATA 9,7,5,3,1; OUT_LAST on 1; MEDIAN=5 with one MEDIAN_STB pulse.
- Same frame with OUT_READY toggling 1,0,0,1,… → identical sequence; OUT_DATA stable and STK_HOLD=1 during every stall.
- 10-beat frame 1..10 with IN_LAST on 10 → FRAME_TRUNC pulse after beat 8; outputs 8..1; beats 9 and 10 discarded; next frame 4,4 gives 4,4.
- Single-beat frame 0xFFFF with IN_LAST → one output 0xFFFF with OUT_LAST=1; MEDIAN=0xFFFF.
- HARD_RESET_N low after 3 beats of a frame → FLUSH restarts; next frame 2,6 gives 6,2 with no stale values.
